pong_msg_receiver: RTL

- Receive side of the board-to-board Pong link; the far end of the message sender on the opposite board.
- Deserialises 8N1 UART bytes from UART_RXD and assembles them into typed frames: ball, miss, new-game, new-game-ack.
- Presents each completed message to the local game-state logic through a hold-until-acked handshake.
- Sits in the top-level chip interface between the UART pins and the game-state FSM.

---
 rtl/pong_msg_pkg.sv | 48 ++++
 rtl/uart_rx_byte.sv | 121 ++++++++++++
 rtl/pong_msg_receiver.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pong_msg_pkg.sv
// Shared definitions for the Pong board-to-board message link.
// Used by both the sender and the receiver so type codes and frame
// layout stay in lock-step. PONG_RX_CHECKSUM_EN selects whether frames
// carry a trailing XOR checksum byte (and hence a CSUM frame state).
package pong_msg_pkg;

  localparam logic [7:0] MSG_BALL    = 8'hA1;
  localparam logic [7:0] MSG_MISS    = 8'hA2;
  localparam logic [7:0] MSG_NEWGAME = 8'hA3;
  localparam logic [7:0] MSG_ACK     = 8'hA4;

`ifdef PONG_RX_CHECKSUM_EN
  typedef enum logic [1:0] {HDR, PAYLOAD, CSUM, HOLD} frame_state_t;
`else
  typedef enum logic [1:0] {HDR, PAYLOAD, HOLD} frame_state_t;
`endif

  // True for the four type codes the link understands.
  function automatic logic type_known(input logic [7:0] t);
    return (t == MSG_BALL) || (t == MSG_MISS) || (t == MSG_NEWGAME) || (t == MSG_ACK);
  endfunction

  // Number of payload bytes following the type byte.
  function automatic logic [1:0] payload_len(input logic [7:0] t);
    logic [1:0] n;
    case (t)
      MSG_BALL:    n = 2'd3;
      MSG_MISS:    n = 2'd2;
      MSG_NEWGAME: n = 2'd1;
      default:     n = 2'd0;
    endcase
    return n;
  endfunction

  // One-hot type flags ordered {ack, new_game, miss, ball}.
  function automatic logic [3:0] type_flags(input logic [7:0] t);
    logic [3:0] f;
    case (t)
      MSG_BALL:    f = 4'b0001;
      MSG_MISS:    f = 4'b0010;
      MSG_NEWGAME: f = 4'b0100;
      MSG_ACK:     f = 4'b1000;
      default:     f = 4'b0000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF input synchroniser, start-bit
// qualification at half a bit, mid-bit sampling, stop-bit check.
// After a framing error it waits for the line to go idle (high) before
// hunting for the next start bit, so a long low line is one error only.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       UART_RXD,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} rx_state_t;

  logic            rxd_meta_reg, rxd_sync_reg;
  rx_state_t       state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic            valid_reg, valid_next;
  logic            ferr_reg, ferr_next;

  // Bring the asynchronous serial line into the clock domain.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rxd_meta_reg <= 1'b1;
      rxd_sync_reg <= 1'b1;
    end else begin
      rxd_meta_reg <= UART_RXD;
      rxd_sync_reg <= rxd_meta_reg;
    end
  end

  // Byte engine state and datapath registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      valid_reg <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      valid_reg <= valid_next;
      ferr_reg  <= ferr_next;
    end
  end

  // Bit timing: qualify start at half a bit, then sample every bit centre.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rxd_sync_reg) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          bit_next = '0;
          state_next = rxd_sync_reg ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxd_sync_reg, shift_reg[7:1]};
          if (bit_reg == 3'd7) state_next = STOP;
          else                 bit_next   = bit_reg + 3'd1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rxd_sync_reg) begin
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rxd_sync_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign byte_valid  = valid_reg;
  assign byte_data   = shift_reg;
  assign framing_err = ferr_reg;
  assign rx_busy     = (state_reg != IDLE);

endmodule

// File: rtl/pong_msg_receiver.sv
// Receive side of the Pong board-to-board link. Assembles UART bytes
// into ball / miss / new-game / ack frames and holds each message until
// the game logic acknowledges it. Build option PONG_RX_CHECKSUM_EN adds
// a trailing XOR checksum byte to every frame.
module pong_msg_receiver
  import pong_msg_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       UART_RXD,
  output logic       UART_CTS,
  output logic       new_message_received,
  input  logic       message_acked,
  output logic       ball_message_rx,
  output logic       miss_message_rx,
  output logic       new_game_message_rx,
  output logic       new_game_ack_message_rx,
  output logic [8:0] ball_y_rx,
  output logic [3:0] velocity_x_rx,
  output logic [3:0] velocity_y_rx,
  output logic [4:0] my_score_rx,
  output logic [4:0] your_score_rx,
  output logic       you_should_serve_rx,
  output logic       you_serve_first_rx,
  output logic       rx_error
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW           = $clog2(TO_LIMIT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

  logic       byte_valid, framing_err, rx_busy;
  logic [7:0] byte_data;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .UART_RXD    (UART_RXD),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .framing_err (framing_err),
    .rx_busy     (rx_busy)
  );

  frame_state_t  state_reg, state_next;
  logic [1:0]    pay_cnt_reg, pay_cnt_next;
  logic [7:0]    type_reg, type_next;
  logic [7:0]    sh_reg [3];
  logic [7:0]    sh_next [3];
  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          msg_valid_reg, msg_valid_next;
  logic [3:0]    flags_reg, flags_next;
  logic [8:0]    ball_y_reg, ball_y_next;
  logic [3:0]    vx_reg, vx_next, vy_reg, vy_next;
  logic [4:0]    my_score_reg, my_score_next, your_score_reg, your_score_next;
  logic          serve_reg, serve_next, first_reg, first_next;
  logic          err_reg, err_next;
  logic          deliver, timeout, in_frame;
`ifdef PONG_RX_CHECKSUM_EN
  logic [7:0]    csum_reg, csum_next;

  // Running XOR of type and payload bytes.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) csum_reg <= '0;
    else       csum_reg <= csum_next;
  end
`endif

  // Frame FSM, shadow payload and message output registers.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg      <= HDR;
      pay_cnt_reg    <= '0;
      type_reg       <= '0;
      sh_reg         <= '{default: '0};
      to_cnt_reg     <= '0;
      msg_valid_reg  <= 1'b0;
      flags_reg      <= '0;
      ball_y_reg     <= '0;
      vx_reg         <= '0;
      vy_reg         <= '0;
      my_score_reg   <= '0;
      your_score_reg <= '0;
      serve_reg      <= 1'b0;
      first_reg      <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pay_cnt_reg    <= pay_cnt_next;
      type_reg       <= type_next;
      sh_reg         <= sh_next;
      to_cnt_reg     <= to_cnt_next;
      msg_valid_reg  <= msg_valid_next;
      flags_reg      <= flags_next;
      ball_y_reg     <= ball_y_next;
      vx_reg         <= vx_next;
      vy_reg         <= vy_next;
      my_score_reg   <= my_score_next;
      your_score_reg <= your_score_next;
      serve_reg      <= serve_next;
      first_reg      <= first_next;
      err_reg        <= err_next;
    end
  end

  // Next-state logic: frame assembly, checks, delivery and ack handling.
  always_comb begin
    state_next      = state_reg;
    pay_cnt_next    = pay_cnt_reg;
    type_next       = type_reg;
    sh_next         = sh_reg;
    msg_valid_next  = msg_valid_reg;
    flags_next      = flags_reg;
    ball_y_next     = ball_y_reg;
    vx_next         = vx_reg;
    vy_next         = vy_reg;
    my_score_next   = my_score_reg;
    your_score_next = your_score_reg;
    serve_next      = serve_reg;
    first_next      = first_reg;
    err_next        = 1'b0;
    deliver         = 1'b0;
`ifdef PONG_RX_CHECKSUM_EN
    csum_next       = csum_reg;
    in_frame        = (state_reg == PAYLOAD) || (state_reg == CSUM);
`else
    in_frame        = (state_reg == PAYLOAD);
`endif
    // Idle-gap timer only runs while a frame is partly received and the
    // line shows no start bit.
    timeout     = (to_cnt_reg == TO_LAST);
    to_cnt_next = (in_frame && !rx_busy && !byte_valid && !timeout) ? to_cnt_reg + TW'(1) : '0;

    case (state_reg)
      HDR: begin
        if (byte_valid) begin
          if (type_known(byte_data)) begin
            type_next    = byte_data;
            pay_cnt_next = '0;
`ifdef PONG_RX_CHECKSUM_EN
            csum_next  = byte_data;
            state_next = (payload_len(byte_data) == 2'd0) ? CSUM : PAYLOAD;
`else
            if (payload_len(byte_data) == 2'd0) deliver    = 1'b1;
            else                                state_next = PAYLOAD;
`endif
          end else begin
            err_next = 1'b1;
          end
        end else if (framing_err) begin
          err_next = 1'b1;
        end
      end
      PAYLOAD: begin
        if (byte_valid) begin
          sh_next[pay_cnt_reg] = byte_data;
          pay_cnt_next         = pay_cnt_reg + 2'd1;
`ifdef PONG_RX_CHECKSUM_EN
          csum_next = csum_reg ^ byte_data;
          if (pay_cnt_reg == payload_len(type_reg) - 2'd1) state_next = CSUM;
`else
          if (pay_cnt_reg == payload_len(type_reg) - 2'd1) deliver = 1'b1;
`endif
        end else if (framing_err || timeout) begin
          err_next   = 1'b1;
          state_next = HDR;
        end
      end
`ifdef PONG_RX_CHECKSUM_EN
      CSUM: begin
        if (byte_valid) begin
          if (byte_data == csum_reg) begin
            deliver = 1'b1;
          end else begin
            err_next   = 1'b1;
            state_next = HDR;
          end
        end else if (framing_err || timeout) begin
          err_next   = 1'b1;
          state_next = HDR;
        end
      end
`endif
      HOLD: begin
        // Anything arriving while a message is held is dropped.
        if (byte_valid || framing_err) err_next = 1'b1;
        if (message_acked) begin
          msg_valid_next = 1'b0;
          flags_next     = '0;
          state_next     = HDR;
        end
      end
      default: state_next = HDR;
    endcase

    // Publish the completed frame; only the fields of its type change.
    if (deliver) begin
      msg_valid_next = 1'b1;
      flags_next     = type_flags(type_next);
      state_next     = HOLD;
      case (type_next)
        MSG_BALL: begin
          ball_y_next = {sh_next[0], sh_next[1][7]};
          vx_next     = sh_next[1][3:0];
          vy_next     = sh_next[2][3:0];
        end
        MSG_MISS: begin
          my_score_next   = sh_next[0][4:0];
          your_score_next = sh_next[1][4:0];
          serve_next      = sh_next[1][5];
        end
        MSG_NEWGAME: first_next = sh_next[0][0];
        default: ;
      endcase
    end
  end

  assign UART_CTS                = (state_reg == HOLD);
  assign new_message_received    = msg_valid_reg;
  assign ball_message_rx         = flags_reg[0];
  assign miss_message_rx         = flags_reg[1];
  assign new_game_message_rx     = flags_reg[2];
  assign new_game_ack_message_rx = flags_reg[3];
  assign ball_y_rx               = ball_y_reg;
  assign velocity_x_rx           = vx_reg;
  assign velocity_y_rx           = vy_reg;
  assign my_score_rx             = my_score_reg;
  assign your_score_rx           = your_score_reg;
  assign you_should_serve_rx     = serve_reg;
  assign you_serve_first_rx      = first_reg;
  assign rx_error                = err_reg;

endmodule
